// File: rtl/mmu_pkg.sv
// Shared defaults, width helpers and the weight-loader state type for the matrix multiply unit.
package mmu_pkg;
   localparam int MMU_ROWS = 16;
   localparam int MMU_COLS = 16;
   localparam int MMU_DW   = 8;
   localparam int MMU_OW   = 20;

   typedef enum logic [1:0] {
      W_EMPTY = 2'd0,
      W_LOAD  = 2'd1,
      W_FULL  = 2'd2
   } w_state_t;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

   // Full-precision column sum: product width plus one carry bit per tree level.
   function automatic int acc_width(input int dw, input int rows);
      return 2 * dw + clog2(rows);
   endfunction
endpackage

// File: rtl/mmu_param_array_if.sv
// Weight-load, activation and result handshakes of the matrix multiply unit.
interface mmu_param_array_if
   import mmu_pkg::*;
#(
   parameter int ROWS = MMU_ROWS,
   parameter int COLS = MMU_COLS,
   parameter int DW   = MMU_DW,
   parameter int OW   = MMU_OW
);
   logic               w_valid;
   logic               w_ready;
   logic [COLS*DW-1:0] w_data;
   logic               w_swap;
   logic               w_full;
   logic               w_bank;
   logic               a_valid;
   logic               a_ready;
   logic [ROWS*DW-1:0] a_data;
   logic               out_valid;
   logic               out_ready;
   logic [COLS*OW-1:0] out_data;

   modport master (
      output w_valid, w_data, w_swap, a_valid, a_data, out_ready,
      input  w_ready, w_full, w_bank, a_ready, out_valid, out_data
   );

   modport slave (
      input  w_valid, w_data, w_swap, a_valid, a_data, out_ready,
      output w_ready, w_full, w_bank, a_ready, out_valid, out_data
   );
endinterface

// File: rtl/mmu_adder_tree.sv
// Registered binary reduction of one column: ROWS signed IW-bit inputs, clog2(ROWS) pipeline stages.
// Nodes are heap-indexed (root 1, children 2k/2k+1); nodes k >= ROWS/2 add two sign-extended inputs.
module mmu_adder_tree
   import mmu_pkg::*;
#(
   parameter  int ROWS = MMU_ROWS,
   parameter  int IW   = 2 * MMU_DW,
   localparam int LV   = clog2(ROWS),
   localparam int SW   = IW + LV
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_en,
   input  logic [ROWS*IW-1:0] i_data,
   output logic [SW-1:0]      o_sum
);
   logic signed [SW-1:0] w_leaf [ROWS];
   logic signed [SW-1:0] r_node [1:ROWS-1];

   for (genvar i = 0; i < ROWS; i++) begin : g_leaf
      assign w_leaf[i] = SW'($signed(i_data[i*IW +: IW]));
   end

   for (genvar k = 1; k < ROWS; k++) begin : g_node
      if (2 * k >= ROWS) begin : g_bottom
         always_ff @(posedge clk or posedge reset) begin
            if (reset)     r_node[k] <= '0;
            else if (i_en) r_node[k] <= w_leaf[2*k-ROWS] + w_leaf[2*k+1-ROWS];
         end
      end else begin : g_inner
         always_ff @(posedge clk or posedge reset) begin
            if (reset)     r_node[k] <= '0;
            else if (i_en) r_node[k] <= r_node[2*k] + r_node[2*k+1];
         end
      end
   end

   assign o_sum = r_node[1];
endmodule

// File: rtl/mmu_param_array.sv
// Weight-stationary ROWSxCOLS matrix multiply: double-buffered weights, pipelined product/adder-tree datapath.
// Define MMU_SATURATE_EN to clamp each output lane to OW bits; otherwise lanes wrap.
//   state   | meaning
//   W_EMPTY | shadow bank empty, next beat writes row 0
//   W_LOAD  | shadow bank partially written, r_wcnt is next row
//   W_FULL  | shadow bank complete, waiting for w_swap
module mmu_param_array
   import mmu_pkg::*;
#(
   parameter int ROWS = MMU_ROWS,
   parameter int COLS = MMU_COLS,
   parameter int DW   = MMU_DW,
   parameter int OW   = MMU_OW
) (
   input  logic             clk,
   input  logic             reset,
   mmu_param_array_if.slave bus
);
   localparam int LV = clog2(ROWS);
   localparam int PW = 2 * DW;
   localparam int AW = acc_width(DW, ROWS);

   w_state_t           r_state, w_state_nxt;
   logic [LV-1:0]      r_wcnt, w_wcnt_nxt;
   logic               r_sel, w_sel_nxt;
   logic               w_we;
   logic               w_wr_rdy;
   logic               w_en;
   logic [LV:0]        r_vld;
   logic [COLS*DW-1:0] r_bank [2][ROWS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= W_EMPTY;
         r_wcnt  <= '0;
         r_sel   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
         r_sel   <= w_sel_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_sel_nxt   = r_sel;
      w_wr_rdy    = 1'b0;
      w_we        = 1'b0;
      unique case (r_state)
         W_EMPTY, W_LOAD: begin
            w_wr_rdy = 1'b1;
            if (bus.w_valid) begin
               w_we       = 1'b1;
               w_wcnt_nxt = r_wcnt + 1'b1;
               if (r_state == W_EMPTY)                  w_state_nxt = W_LOAD;
               else if (r_wcnt == LV'(ROWS - 1))        w_state_nxt = W_FULL;
            end
         end
         W_FULL: begin
            if (bus.w_swap) begin
               w_sel_nxt   = ~r_sel;
               w_state_nxt = W_EMPTY;
            end
         end
         default: w_state_nxt = W_EMPTY;
      endcase
   end

   // Beats always land in the bank that is not currently active.
   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               r_bank[b][r] <= '0;
            else if (w_we && (r_sel != 1'(b)) && (r_wcnt == LV'(r)))
               r_bank[b][r] <= bus.w_data;
         end
      end
   end

   assign w_en = !r_vld[LV] || bus.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     r_vld <= '0;
      else if (w_en) r_vld <= {r_vld[LV-1:0], bus.a_valid};
   end

   for (genvar j = 0; j < COLS; j++) begin : g_col
      logic [ROWS*PW-1:0] w_prod;
      logic [ROWS*PW-1:0] r_prod;
      logic [AW-1:0]      w_sum;

      for (genvar i = 0; i < ROWS; i++) begin : g_mul
         logic signed [DW-1:0] w_wt;
         assign w_wt = r_sel ? r_bank[1][i][j*DW +: DW] : r_bank[0][i][j*DW +: DW];
         assign w_prod[i*PW +: PW] = PW'($signed(bus.a_data[i*DW +: DW])) * PW'(w_wt);
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset)     r_prod <= '0;
         else if (w_en) r_prod <= w_prod;
      end

      mmu_adder_tree #(.ROWS(ROWS), .IW(PW)) u_tree (
         .clk    (clk),
         .reset  (reset),
         .i_en   (w_en),
         .i_data (r_prod),
         .o_sum  (w_sum)
      );

`ifdef MMU_SATURATE_EN
      logic [AW-OW:0] w_hi;
      logic [OW-1:0]  w_lane;
      assign w_hi = w_sum[AW-1:OW-1];
      // Bits above the lane's sign bit must all match it, otherwise the sum is out of range.
      always_comb begin
         w_lane = w_sum[OW-1:0];
         if (w_hi != '0 && w_hi != '1)
            w_lane = w_sum[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end
      assign bus.out_data[j*OW +: OW] = w_lane;
`else
      assign bus.out_data[j*OW +: OW] = OW'(w_sum);
`endif
   end

   assign bus.w_ready   = w_wr_rdy;
   assign bus.w_full    = (r_state == W_FULL);
   assign bus.w_bank    = r_sel;
   assign bus.a_ready   = w_en;
   assign bus.out_valid = r_vld[LV];
endmodule
